// File: rtl/fixedpointscaler_pipe_if.sv
// Handshake and packed per-lane data bundle for the fixed-point scaler pipeline.
// The master side drives beats and the downstream ready; the slave side is the scaler.
interface fixedpointscaler_pipe_if #(
    parameter int N  = 4,
    parameter int BA = 27,
    parameter int BB = 16,
    parameter int BC = 27,
    parameter int BO = 16
);
    logic            i_valid;
    logic            i_ready;
    logic            i_sub;
    logic            i_rnd;
    logic [N*BA-1:0] i_a;
    logic [N*BA-1:0] i_d;
    logic [N*BB-1:0] i_b;
    logic [N*BC-1:0] i_c;
    logic            o_valid;
    logic            o_ready;
    logic [N*BO-1:0] o_p;
    logic [N-1:0]    o_sat;
    logic            sat_clr;

    modport master (
        output i_valid, i_sub, i_rnd, i_a, i_d, i_b, i_c, o_ready, sat_clr,
        input  i_ready, o_valid, o_p, o_sat
    );

    modport slave (
        input  i_valid, i_sub, i_rnd, i_a, i_d, i_b, i_c, o_ready, sat_clr,
        output i_ready, o_valid, o_p, o_sat
    );
endinterface

// File: rtl/fixedpointscaler_pipe.sv
// N-lane fused scaler: p = sat(rnd((a +/- d) * b + c) >>> SHIFT).
// Five register stages share one valid/ready handshake; a stall at the
// output freezes every stage at once, and bubbles are carried, not collapsed.
module fixedpointscaler_pipe #(
    parameter int N     = 4,
    parameter int BA    = 27,
    parameter int BB    = 16,
    parameter int BC    = 27,
    parameter int SHIFT = 8,
    parameter int BO    = 16
) (
    input  logic                   clk,
    input  logic                   clr_n,
    fixedpointscaler_pipe_if.slave bus
);
    // Internal widths: pre-adder, product, exact sum, and sum plus rounding carry.
    localparam int BPRE = BA + 1;
    localparam int BM   = BA + BB + 1;
    localparam int BP   = ((BM > BC) ? BM : BC) + 1;
    localparam int BR   = BP + 1;

    // Saturation bounds expressed at the rounded-sum width.
    localparam logic signed [BR-1:0] P_MAX = {{(BR-BO+1){1'b0}}, {(BO-1){1'b1}}};
    localparam logic signed [BR-1:0] P_MIN = {{(BR-BO+1){1'b1}}, {(BO-1){1'b0}}};
    // Half an output LSB; zero when there is no shift, which disables rounding.
    localparam logic [BR-1:0] RND_K =
        (SHIFT > 0) ? (BR'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    // Shared advance: every stage moves when the output slot is empty or taken.
    logic adv;

    // Unpacked lane views of the input bus.
    logic [BA-1:0] a_in [N];
    logic [BA-1:0] d_in [N];
    logic [BB-1:0] b_in [N];
    logic [BC-1:0] c_in [N];

    // Stage 1: registered operands and per-beat controls.
    logic          v1_q, v1_d;
    logic          sub1_q, sub1_d;
    logic          rnd1_q, rnd1_d;
    logic [BA-1:0] a1_q [N];
    logic [BA-1:0] a1_d [N];
    logic [BA-1:0] d1_q [N];
    logic [BA-1:0] d1_d [N];
    logic [BB-1:0] b1_q [N];
    logic [BB-1:0] b1_d [N];
    logic [BC-1:0] c1_q [N];
    logic [BC-1:0] c1_d [N];

    // Stage 2: pre-adder result.
    logic            v2_q, v2_d;
    logic            rnd2_q, rnd2_d;
    logic [BPRE-1:0] pre2_q [N];
    logic [BPRE-1:0] pre2_d [N];
    logic [BB-1:0]   b2_q [N];
    logic [BB-1:0]   b2_d [N];
    logic [BC-1:0]   c2_q [N];
    logic [BC-1:0]   c2_d [N];

    // Stage 3: product.
    logic          v3_q, v3_d;
    logic          rnd3_q, rnd3_d;
    logic [BM-1:0] m3_q [N];
    logic [BM-1:0] m3_d [N];
    logic [BC-1:0] c3_q [N];
    logic [BC-1:0] c3_d [N];

    // Stage 4: exact sum.
    logic          v4_q, v4_d;
    logic          rnd4_q, rnd4_d;
    logic [BP-1:0] s4_q [N];
    logic [BP-1:0] s4_d [N];

    // Stage 5: saturated output and sticky flags.
    logic          v5_q, v5_d;
    logic [BO-1:0] p5_q [N];
    logic [BO-1:0] p5_d [N];
    logic [N-1:0]  sat_q, sat_d;

    // Stage 5 working values: rounded sum and shifted result.
    logic signed [BR-1:0] r_w [N];
    logic signed [BR-1:0] q_w [N];

    assign adv         = !v5_q || bus.o_ready;
    assign bus.i_ready = adv;
    assign bus.o_valid = v5_q;
    assign bus.o_sat   = sat_q;

    for (genvar k = 0; k < N; k++) begin : g_lane_io
        assign a_in[k]               = bus.i_a[k*BA +: BA];
        assign d_in[k]               = bus.i_d[k*BA +: BA];
        assign b_in[k]               = bus.i_b[k*BB +: BB];
        assign c_in[k]               = bus.i_c[k*BC +: BC];
        assign bus.o_p[k*BO +: BO]   = p5_q[k];
    end

    // Stage 1 next state: take a new beat only when it is valid and the pipe advances.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        v1_d   = adv ? bus.i_valid : v1_q;
        sub1_d = sub1_q;
        rnd1_d = rnd1_q;
        a1_d   = a1_q;
        d1_d   = d1_q;
        b1_d   = b1_q;
        c1_d   = c1_q;
        if (adv && bus.i_valid) begin
            sub1_d = bus.i_sub;
            rnd1_d = bus.i_rnd;
            a1_d   = a_in;
            d1_d   = d_in;
            b1_d   = b_in;
            c1_d   = c_in;
        end
    end

    // Stage 2 next state: sign-extended pre-add or pre-subtract.
    always_comb begin
        v2_d   = adv ? v1_q : v2_q;
        rnd2_d = rnd2_q;
        pre2_d = pre2_q;
        b2_d   = b2_q;
        c2_d   = c2_q;
        if (adv && v1_q) begin
            rnd2_d = rnd1_q;
            b2_d   = b1_q;
            c2_d   = c1_q;
            for (int k = 0; k < N; k++) begin
                if (sub1_q) begin
                    pre2_d[k] = {a1_q[k][BA-1], a1_q[k]} - {d1_q[k][BA-1], d1_q[k]};
                end else begin
                    pre2_d[k] = {a1_q[k][BA-1], a1_q[k]} + {d1_q[k][BA-1], d1_q[k]};
                end
            end
        end
    end

    // Stage 3 next state: full-width signed product of pre and b.
    always_comb begin
        v3_d   = adv ? v2_q : v3_q;
        rnd3_d = rnd3_q;
        m3_d   = m3_q;
        c3_d   = c3_q;
        if (adv && v2_q) begin
            rnd3_d = rnd2_q;
            c3_d   = c2_q;
            for (int k = 0; k < N; k++) begin
                m3_d[k] = {{(BM-BPRE){pre2_q[k][BPRE-1]}}, pre2_q[k]}
                        * {{(BM-BB){b2_q[k][BB-1]}}, b2_q[k]};
            end
        end
    end

    // Stage 4 next state: add the sign-extended addend; BP is wide enough to never wrap.
    always_comb begin
        v4_d   = adv ? v3_q : v4_q;
        rnd4_d = rnd4_q;
        s4_d   = s4_q;
        if (adv && v3_q) begin
            rnd4_d = rnd3_q;
            for (int k = 0; k < N; k++) begin
                s4_d[k] = {{(BP-BM){m3_q[k][BM-1]}}, m3_q[k]}
                        + {{(BP-BC){c3_q[k][BC-1]}}, c3_q[k]};
            end
        end
    end

    // Stage 5 next state: round, arithmetic shift, clamp; a fresh saturation beats sat_clr.
    always_comb begin
        v5_d  = adv ? v4_q : v5_q;
        p5_d  = p5_q;
        sat_d = bus.sat_clr ? '0 : sat_q;
        for (int k = 0; k < N; k++) begin
            r_w[k] = {s4_q[k][BP-1], s4_q[k]} + (rnd4_q ? RND_K : '0);
            q_w[k] = r_w[k] >>> SHIFT;
            if (adv && v4_q) begin
                if (q_w[k] > P_MAX) begin
                    p5_d[k]  = P_MAX[BO-1:0];
                    sat_d[k] = 1'b1;
                end else if (q_w[k] < P_MIN) begin
                    p5_d[k]  = P_MIN[BO-1:0];
                    sat_d[k] = 1'b1;
                end else begin
                    p5_d[k]  = q_w[k][BO-1:0];
                end
            end
        end
    end

    // All pipeline state; reset drops any beats in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: data arrays are cleared along with the valids so o_p reads 0 straight out of reset.
            v1_q   <= 1'b0;
            sub1_q <= 1'b0;
            rnd1_q <= 1'b0;
            a1_q   <= '{default: '0};
            d1_q   <= '{default: '0};
            b1_q   <= '{default: '0};
            c1_q   <= '{default: '0};
            v2_q   <= 1'b0;
            rnd2_q <= 1'b0;
            pre2_q <= '{default: '0};
            b2_q   <= '{default: '0};
            c2_q   <= '{default: '0};
            v3_q   <= 1'b0;
            rnd3_q <= 1'b0;
            m3_q   <= '{default: '0};
            c3_q   <= '{default: '0};
            v4_q   <= 1'b0;
            rnd4_q <= 1'b0;
            s4_q   <= '{default: '0};
            v5_q   <= 1'b0;
            p5_q   <= '{default: '0};
            sat_q  <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples its upstream neighbour's pre-edge value.
            v1_q   <= v1_d;
            sub1_q <= sub1_d;
            rnd1_q <= rnd1_d;
            a1_q   <= a1_d;
            d1_q   <= d1_d;
            b1_q   <= b1_d;
            c1_q   <= c1_d;
            v2_q   <= v2_d;
            rnd2_q <= rnd2_d;
            pre2_q <= pre2_d;
            b2_q   <= b2_d;
            c2_q   <= c2_d;
            v3_q   <= v3_d;
            rnd3_q <= rnd3_d;
            m3_q   <= m3_d;
            c3_q   <= c3_d;
            v4_q   <= v4_d;
            rnd4_q <= rnd4_d;
            s4_q   <= s4_d;
            v5_q   <= v5_d;
            p5_q   <= p5_d;
            sat_q  <= sat_d;
        end
    end
endmodule

// File: tb/tb_fixedpointscaler_pipe.sv
// Directed bench for the N-lane fixed-point scaler pipeline.
module tb_fixedpointscaler_pipe;
    localparam int N     = 4;
    localparam int BA    = 27;
    localparam int BB    = 16;
    localparam int BC    = 27;
    localparam int SHIFT = 8;
    localparam int BO    = 16;

    logic clk = 1'b0;
    logic clr_n;
    int   errors = 0;
    int   checks = 0;

    fixedpointscaler_pipe_if #(.N(N), .BA(BA), .BB(BB), .BC(BC), .BO(BO)) bus ();

    fixedpointscaler_pipe #(
        .N(N), .BA(BA), .BB(BB), .BC(BC), .SHIFT(SHIFT), .BO(BO)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference result for one lane, computed in 64-bit integers.
    function automatic logic [BO-1:0] model_p(input longint a, d, b, c, input bit sub, input bit rnd);
        longint s;
        s = (sub ? a - d : a + d) * b + c;
        if (rnd) s = s + 128;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[BO-1:0];
    endfunction

    task automatic set_lane(input int k, input int a, input int d, input int b, input int c);
        bus.i_a[k*BA +: BA] = BA'(a);
        bus.i_d[k*BA +: BA] = BA'(d);
        bus.i_b[k*BB +: BB] = BB'(b);
        bus.i_c[k*BC +: BC] = BC'(c);
    endtask

    task automatic set_all(input int a, input int d, input int b, input int c, input bit sub, input bit rnd);
        for (int k = 0; k < N; k++) set_lane(k, a, d, b, c);
        bus.i_sub = sub;
        bus.i_rnd = rnd;
    endtask

    // One-beat pulse, then count edges from the capture edge until o_valid (bounded).
    task automatic send_wait(output int lat);
        @(posedge clk); #1; bus.i_valid = 1'b1;
        @(posedge clk); #1; bus.i_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1 || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_p !== '0) begin errors++; $display("FAIL reset_o_p: got %h expected 0", bus.o_p); end
        checks++; if (bus.o_sat !== '0) begin errors++; $display("FAIL reset_o_sat: got %b expected 0", bus.o_sat); end
        checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b expected 1", bus.i_ready); end
        @(negedge clk);
        clr_n = 1'b1;
        bus.o_ready = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        set_all(100, 28, 2, 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        checks++; if (bus.o_p !== {N{16'd1}}) begin errors++; $display("FAIL basic_add: got %h expected %h", bus.o_p, {N{16'd1}}); end
        checks++; if (bus.o_sat !== 4'h0) begin errors++; $display("FAIL basic_sat: got %b expected 0000", bus.o_sat); end
        set_all(300, 44, 3, 256, 1'b1, 1'b0);
        send_wait(lat);
        checks++; if (lat !== 5 || bus.o_p !== {N{16'd4}}) begin errors++; $display("FAIL basic_sub: got %h lat %0d expected %h lat 5", bus.o_p, lat, {N{16'd4}}); end
    endtask

    task automatic test_rounding;
        int          rd_d [5] = '{128, 128, -128, -128, 127};
        bit          rd_r [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] rd_e [5] = '{16'd1, 16'd0, 16'd0, 16'hFFFF, 16'd0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            set_all(0, rd_d[i], 1, 0, 1'b0, rd_r[i]);
            send_wait(lat);
            checks++;
            if (lat !== 5 || bus.o_p !== {N{rd_e[i]}}) begin
                errors++;
                $display("FAIL round_%0d: got %h lat %0d expected %h lat 5", i, bus.o_p, lat, {N{rd_e[i]}});
            end
        end
    endtask

    task automatic test_saturation;
        int lat;
        set_all(1 << 20, 0, 1 << 10, 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (bus.o_p !== {N{16'h7FFF}}) begin errors++; $display("FAIL sat_pos: got %h expected %h", bus.o_p, {N{16'h7FFF}}); end
        checks++; if (bus.o_sat !== 4'hF) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1111", bus.o_sat); end
        set_all(1 << 20, 0, -(1 << 10), 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (bus.o_p !== {N{16'h8000}}) begin errors++; $display("FAIL sat_neg: got %h expected %h", bus.o_p, {N{16'h8000}}); end
        set_all(100, 28, 2, 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (bus.o_p !== {N{16'd1}} || bus.o_sat !== 4'hF) begin errors++; $display("FAIL sat_sticky: got p=%h sat=%b expected p=%h sat=1111", bus.o_p, bus.o_sat, {N{16'd1}}); end
        @(posedge clk); #1; bus.sat_clr = 1'b1;
        @(posedge clk); #1; bus.sat_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_sat !== 4'h0) begin errors++; $display("FAIL sat_clr: got %b expected 0000", bus.o_sat); end
        set_all(1 << 20, 0, 1 << 10, 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (bus.o_sat !== 4'hF) begin errors++; $display("FAIL sat_reset_flag: got %b expected 1111", bus.o_sat); end
        // Only lane 0 saturates while sat_clr is high on the same load edge.
        set_all(1 << 20, 0, 1, 0, 1'b0, 1'b0);
        set_lane(0, 1 << 20, 0, 1 << 10, 0);
        @(posedge clk); #1; bus.i_valid = 1'b1;
        @(posedge clk); #1; bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; bus.sat_clr = 1'b1;
        @(posedge clk); #1; bus.sat_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_p !== {16'h1000, 16'h1000, 16'h1000, 16'h7FFF}) begin errors++; $display("FAIL sat_coincident_p: got v=%b p=%h expected v=1 p=1000100010007fff", bus.o_valid, bus.o_p); end
        checks++; if (bus.o_sat !== 4'b0001) begin errors++; $display("FAIL sat_coincident_flag: got %b expected 0001", bus.o_sat); end
    endtask

    task automatic bp_load(input int j);
        for (int k = 0; k < N; k++) set_lane(k, (j + 1) * (k + 1) * 37, j * 11, k - 2 + j, j * 100 - 500);
        bus.i_sub = j[0];
        bus.i_rnd = j[1];
    endtask

    function automatic logic [N*BO-1:0] bp_expect(input int j);
        logic [N*BO-1:0] e;
        for (int k = 0; k < N; k++) e[k*BO +: BO] = model_p((j + 1) * (k + 1) * 37, j * 11, k - 2 + j, j * 100 - 500, j[0], j[1]);
        return e;
    endfunction

    task automatic test_backpressure;
        int              sent = 0;
        int              rcvd = 0;
        int              cyc  = 0;
        int              extra = 0;
        bit              stalled = 1'b0;
        bit              bad_ready = 1'b0;
        logic [N*BO-1:0] last_p = '0;
        logic [N*BO-1:0] exp_p;
        while (rcvd < 20 && cyc < 400) begin
            @(posedge clk); #1;
            bus.o_ready = ($urandom_range(0, 1) == 1);
            if (sent < 20) begin
                bp_load(sent);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus.i_ready !== (!bus.o_valid || bus.o_ready)) bad_ready = 1'b1;
            if (stalled) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_p !== last_p) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b p=%h expected v=1 p=%h", bus.o_valid, bus.o_p, last_p);
                end
            end
            if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
                exp_p = bp_expect(rcvd);
                checks++;
                if (bus.o_p !== exp_p) begin
                    errors++;
                    $display("FAIL bp_beat_%0d: got %h expected %h", rcvd, bus.o_p, exp_p);
                end
                rcvd++;
            end
            stalled = (bus.o_valid === 1'b1) && (bus.o_ready === 1'b0);
            last_p  = bus.o_p;
            if (bus.i_valid === 1'b1 && bus.i_ready === 1'b1) sent++;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        checks++; if (bad_ready) begin errors++; $display("FAIL bp_i_ready: got mismatch against !o_valid|o_ready expected always equal"); end
        checks++; if (rcvd !== 20 || sent !== 20) begin errors++; $display("FAIL bp_count: got sent=%0d rcvd=%0d expected 20/20", sent, rcvd); end
        repeat (8) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) extra++;
            @(posedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_duplicate: got %0d extra beats expected 0", extra); end
    endtask

    task automatic test_bubbles;
        bit              pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [N*BO-1:0] exp_p;
        int              j;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (t < 5) begin
                for (int k = 0; k < N; k++) set_lane(k, 256 * (10 * t + k + 1), 0, 1, 0);
                bus.i_sub   = 1'b0;
                bus.i_rnd   = 1'b0;
                bus.i_valid = pat[t];
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
            if (t < 5) begin
                checks++;
                if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bubble_early_%0d: got %b expected 0", t, bus.o_valid); end
            end else begin
                j = t - 5;
                checks++;
                if (bus.o_valid !== pat[j]) begin errors++; $display("FAIL bubble_valid_%0d: got %b expected %b", j, bus.o_valid, pat[j]); end
                if (pat[j]) begin
                    for (int k = 0; k < N; k++) exp_p[k*BO +: BO] = 16'(10 * j + k + 1);
                    checks++;
                    if (bus.o_p !== exp_p) begin errors++; $display("FAIL bubble_data_%0d: got %h expected %h", j, bus.o_p, exp_p); end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int ghost = 0;
        set_all(1 << 20, 0, 1 << 10, 0, 1'b0, 1'b0);
        @(posedge clk); #1; bus.i_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1; bus.i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b expected 1", bus.o_valid); end
        clr_n = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_p !== '0) begin errors++; $display("FAIL rst_mid_p: got %h expected 0", bus.o_p); end
        checks++; if (bus.o_sat !== '0) begin errors++; $display("FAIL rst_mid_sat: got %b expected 0", bus.o_sat); end
        @(posedge clk); #3; clr_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) ghost++;
            @(posedge clk);
        end
        checks++; if (ghost !== 0) begin errors++; $display("FAIL rst_mid_ghost: got %0d old beats expected 0", ghost); end
        set_all(100, 28, 2, 0, 1'b0, 1'b0);
        send_wait(lat);
        checks++; if (lat !== 5 || bus.o_p !== {N{16'd1}} || bus.o_sat !== 4'h0) begin errors++; $display("FAIL rst_mid_new: got p=%h sat=%b lat %0d expected p=%h sat=0000 lat 5", bus.o_p, bus.o_sat, lat, {N{16'd1}}); end
    endtask

    initial begin
        clr_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_rnd   = 1'b0;
        bus.i_a     = '0;
        bus.i_d     = '0;
        bus.i_b     = '0;
        bus.i_c     = '0;
        bus.o_ready = 1'b0;
        bus.sat_clr = 1'b0;
        test_reset;
        test_basic;
        test_rounding;
        test_saturation;
        test_backpressure;
        test_bubbles;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
